// File: rtl/analysis_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// analysis_ctrl_pkg
// Shared types and constants for the spectral peak finder (analysis_ctrl) and
// its magnitude unit (mag_sq).
//   state_t   : controller FSM states
//   BINS      : bins per frame
//   IDX_W     : bin-index width
//   MAG_W     : magnitude width
//   RE_MSB /
//   IM_MSB    : top bit of the real / imaginary field inside one bin word
//   abs16()   : two's complement 16-bit value -> 16-bit unsigned magnitude
// -----------------------------------------------------------------------------
package analysis_ctrl_pkg;

   localparam int BINS   = 16;
   localparam int IDX_W  = 4;
   localparam int MAG_W  = 32;
   localparam int BIN_W  = 32;
   localparam int HALF_W = 16;
   localparam int RE_MSB = 31;
   localparam int IM_MSB = 15;

   typedef enum logic [1:0] {
      LOAD = 2'd0,
      SCAN = 2'd1,
      OUT  = 2'd2,
      HALT = 2'd3
   } state_t;

   typedef logic [IDX_W-1:0] idx_t;
   typedef logic [MAG_W-1:0] mag_t;

   // Unsigned magnitude of a 16-bit two's complement value. -32768 maps to
   // 16'h8000, which read as unsigned is exactly 32768, so no extra bit is
   // needed.
   function automatic logic [HALF_W-1:0] abs16(input logic [HALF_W-1:0] x);
      return x[HALF_W-1] ? (~x + 16'd1) : x;
   endfunction

endpackage

// File: rtl/mag_sq.sv
// -----------------------------------------------------------------------------
// mag_sq
// Registered squared magnitude |re|^2 + |im|^2 of one FFT bin, one cycle of
// latency. A valid flag and the bin index travel alongside the result so the
// consumer knows which bin the registered magnitude belongs to.
// Ports:
//   clk_i   : clock
//   rst_ni  : synchronous active-low reset
//   valid_i : bin_i / idx_i carry a bin this cycle
//   idx_i   : index of the bin being presented
//   bin_i   : bin word, real in [31:16], imaginary in [15:0]
//   valid_o : mag_o / idx_o hold the result for a bin issued last cycle
//   idx_o   : index of that bin
//   mag_o   : its squared magnitude, 32-bit unsigned
// -----------------------------------------------------------------------------
module mag_sq
   import analysis_ctrl_pkg::*;
(
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             valid_i,
   input  idx_t             idx_i,
   input  logic [BIN_W-1:0] bin_i,
   output logic             valid_o,
   output idx_t             idx_o,
   output mag_t             mag_o
);

   logic [HALF_W-1:0] re_abs;
   logic [HALF_W-1:0] im_abs;
   mag_t              re_sq;
   mag_t              im_sq;
   mag_t              mag_d;

   mag_t              mag_q;
   logic              valid_q;
   idx_t              idx_q;

   // Each square is at most 2^30, so the sum (at most 2^31) fits in 32 bits.
   // NOTE: every always_comb output is assigned on every path, so no latch
   // can be inferred.
   always_comb begin
      re_abs = abs16(bin_i[RE_MSB -: HALF_W]);
      im_abs = abs16(bin_i[IM_MSB -: HALF_W]);
      re_sq  = {16'd0, re_abs} * {16'd0, re_abs};
      im_sq  = {16'd0, im_abs} * {16'd0, im_abs};
      mag_d  = re_sq + im_sq;
   end

   // NOTE: state registers use non-blocking assignments so every register
   // samples pre-edge values, independent of statement order.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         mag_q   <= '0;
         valid_q <= 1'b0;
         idx_q   <= '0;
      end else begin
         mag_q   <= mag_d;
         valid_q <= valid_i;
         idx_q   <= idx_i;
      end
   end

   assign mag_o   = mag_q;
   assign valid_o = valid_q;
   assign idx_o   = idx_q;

endmodule

// File: rtl/analysis_ctrl.sv
// -----------------------------------------------------------------------------
// analysis_ctrl
// Collects 16-bin FFT frames, finds the bin of peak squared magnitude with a
// serial scan through one shared mag_sq unit, and hands the winning index to
// a consumer over a valid/ready pair. After FRAMES results have been accepted
// the block halts with all_done high until reset.
// Parameters:
//   FRAMES     : results per run (1..127)
// Ports:
//   clk        : clock, all state changes on its rising edge
//   rst        : synchronous active-low reset
//   fft_d      : bin word, real in [31:16], imaginary in [15:0]
//   fft_valid  : fft_d valid
//   fft_ready  : block accepts a bin (LOAD only)
//   freq       : peak bin index of the last completed frame
//   freq_valid : freq awaits acceptance
//   freq_ready : consumer accepts freq
//   frame_cnt  : results accepted since reset
//   all_done   : FRAMES results accepted; held until reset
// Timing: bin 15 accepted in cycle T -> reads T+1..T+16, compares T+2..T+17,
// freq_valid from T+18.
// -----------------------------------------------------------------------------
module analysis_ctrl
   import analysis_ctrl_pkg::*;
#(
   parameter int FRAMES = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [BIN_W-1:0] fft_d,
   input  logic             fft_valid,
   output logic             fft_ready,
   output logic [IDX_W-1:0] freq,
   output logic             freq_valid,
   input  logic             freq_ready,
   output logic [6:0]       frame_cnt,
   output logic             all_done
);

   localparam idx_t LAST_IDX = idx_t'(BINS - 1);

   // ---------------------------------------------------------------- state
   state_t     state_q;
   idx_t       wr_idx_q;
   idx_t       rd_idx_q;
   logic       rd_done_q;    // all 16 reads of this scan issued
   mag_t       max_q;
   idx_t       max_idx_q;
   idx_t       freq_q;
   logic       freq_valid_q;
   logic [6:0] frame_cnt_q;
   logic       all_done_q;
   logic       fft_ready_q;

   logic [BIN_W-1:0] bin_buf [BINS];

   // ------------------------------------------------------- combinational
   logic       load_xfer;
   logic       out_xfer;
   logic       rd_issue;
   logic       last_cmp;
   logic       mag_valid;
   idx_t       mag_idx;
   mag_t       mag;
   mag_t       max_d;
   idx_t       max_idx_d;
   logic [6:0] frame_cnt_d;

   assign load_xfer   = (state_q == LOAD) && fft_valid && fft_ready_q;
   assign out_xfer    = (state_q == OUT) && freq_valid_q && freq_ready;
   assign rd_issue    = (state_q == SCAN) && !rd_done_q;
   assign last_cmp    = mag_valid && (mag_idx == LAST_IDX);
   assign frame_cnt_d = frame_cnt_q + 7'd1;

   // NOTE: the frame buffer is plain storage with no reset; every entry is
   // rewritten in LOAD before SCAN reads it, so stale data is never used.
   always_ff @(posedge clk) begin
      if (load_xfer) begin
         bin_buf[wr_idx_q] <= fft_d;
      end
   end

   mag_sq u_mag_sq (
      .clk_i   (clk),
      .rst_ni  (rst),
      .valid_i (rd_issue),
      .idx_i   (rd_idx_q),
      .bin_i   (bin_buf[rd_idx_q]),
      .valid_o (mag_valid),
      .idx_o   (mag_idx),
      .mag_o   (mag)
   );

   // Running maximum. Bin 0 seeds the max unconditionally; later bins win
   // only on a strictly greater magnitude, so ties keep the lower index.
   always_comb begin
      max_d     = max_q;
      max_idx_d = max_idx_q;
      if (mag_valid && ((mag_idx == '0) || (mag > max_q))) begin
         max_d     = mag;
         max_idx_d = mag_idx;
      end
   end

   // ------------------------------------------------------------------ FSM
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= LOAD;
         wr_idx_q     <= '0;
         rd_idx_q     <= '0;
         rd_done_q    <= 1'b0;
         max_q        <= '0;
         max_idx_q    <= '0;
         freq_q       <= '0;
         freq_valid_q <= 1'b0;
         frame_cnt_q  <= '0;
         all_done_q   <= 1'b0;
         fft_ready_q  <= 1'b1;
      end else begin
         max_q     <= max_d;
         max_idx_q <= max_idx_d;

         unique case (state_q)
            LOAD: begin
               if (load_xfer) begin
                  wr_idx_q <= wr_idx_q + 1'b1;   // wraps to 0 after bin 15
                  if (wr_idx_q == LAST_IDX) begin
                     state_q     <= SCAN;
                     fft_ready_q <= 1'b0;
                     rd_idx_q    <= '0;
                     rd_done_q   <= 1'b0;
                  end
               end
            end

            SCAN: begin
               if (rd_issue) begin
                  rd_idx_q <= rd_idx_q + 1'b1;
                  if (rd_idx_q == LAST_IDX) begin
                     rd_done_q <= 1'b1;
                  end
               end
               // The compare of bin 15 happens this cycle, so the final
               // winner is the combinational max_idx_d, not max_idx_q.
               if (last_cmp) begin
                  state_q      <= OUT;
                  freq_q       <= max_idx_d;
                  freq_valid_q <= 1'b1;
               end
            end

            OUT: begin
               if (out_xfer) begin
                  freq_valid_q <= 1'b0;
                  frame_cnt_q  <= frame_cnt_d;
                  if (frame_cnt_d == 7'(FRAMES)) begin
                     state_q    <= HALT;
                     all_done_q <= 1'b1;
                  end else begin
                     state_q     <= LOAD;
                     fft_ready_q <= 1'b1;
                  end
               end
            end

            HALT: begin
               // Only reset leaves HALT.
            end

            default: begin
               state_q <= LOAD;
            end
         endcase
      end
   end

   assign fft_ready  = fft_ready_q;
   assign freq       = freq_q;
   assign freq_valid = freq_valid_q;
   assign frame_cnt  = frame_cnt_q;
   assign all_done   = all_done_q;

endmodule

// File: tb/tb_analysis_ctrl.sv
// -----------------------------------------------------------------------------
// tb_analysis_ctrl
// Stimulus sends frames and pushes the expected peak (computed from squared
// magnitudes with plain integer arithmetic) into a queue; an independent
// monitor pops and compares whenever a result is offered and accepted.
// -----------------------------------------------------------------------------
module tb_analysis_ctrl;

   localparam int TB_FRAMES = 4;
   localparam int MAX_WAIT  = 400;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] fft_d = '0;
   logic        fft_valid = 1'b0;
   logic        fft_ready;
   logic [3:0]  freq;
   logic        freq_valid;
   logic        freq_ready = 1'b1;
   logic [6:0]  frame_cnt;
   logic        all_done;

   analysis_ctrl #(.FRAMES(TB_FRAMES)) dut (
      .clk        (clk),
      .rst        (rst),
      .fft_d      (fft_d),
      .fft_valid  (fft_valid),
      .fft_ready  (fft_ready),
      .freq       (freq),
      .freq_valid (freq_valid),
      .freq_ready (freq_ready),
      .frame_cnt  (frame_cnt),
      .all_done   (all_done)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int freq;
      int pre_cnt;
      int t15;
   } exp_t;

   exp_t        exp_q[$];
   int          model_cnt = 0;
   logic [31:0] frm [16];

   bit          ready_rand  = 1'b0;
   bit          ready_level = 1'b1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic fail(input string name);
      checks++;
      errors++;
      $display("FAIL %s: event did not occur as required (cycle %0d)", name, cyc);
   endtask

   // Reference: peak index by squared magnitude, first index wins on ties.
   function automatic int peak_of(input logic [31:0] b [16]);
      longint best = -1;
      int     idx  = 0;
      for (int k = 0; k < 16; k++) begin
         longint re = longint'($signed(b[k][31:16]));
         longint im = longint'($signed(b[k][15:0]));
         longint m  = re * re + im * im;
         if (m > best) begin
            best = m;
            idx  = k;
         end
      end
      return idx;
   endfunction

   // ------------------------------------------------------ freq_ready driver
   initial begin
      forever begin
         @(posedge clk);
         #2;
         if (ready_rand) freq_ready = 1'($urandom_range(0, 1));
         else            freq_ready = ready_level;
      end
   end

   // ---------------------------------------------------------------- monitor
   bit         mon_prev_valid = 1'b0;
   bit         mon_prev_xfer  = 1'b0;
   int         mon_last_pre   = 0;
   int         mon_bins_acc   = 0;
   logic [3:0] mon_held_freq  = '0;

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst) begin
            mon_bins_acc   = 0;
            mon_prev_valid = 1'b0;
            mon_prev_xfer  = 1'b0;
         end else begin
            if (mon_prev_xfer) begin
               check("freq_valid_drop", freq_valid, 0);
               check("frame_cnt_after", frame_cnt, mon_last_pre + 1);
               check("all_done_after", all_done, (mon_last_pre + 1) == TB_FRAMES);
               mon_prev_xfer = 1'b0;
            end
            if (fft_valid && fft_ready) mon_bins_acc++;
            if (all_done) check("halt_fft_ready", fft_ready, 0);

            if (freq_valid && !mon_prev_valid) begin
               if (exp_q.size() == 0) begin
                  fail("unexpected_result");
               end else begin
                  check("latency", cyc - exp_q[0].t15, 18);
                  check("bins_accepted", mon_bins_acc, 16 * (exp_q[0].pre_cnt + 1));
                  check("fft_ready_in_out", fft_ready, 0);
               end
               mon_held_freq = freq;
            end else if (freq_valid) begin
               check("freq_stable", freq, mon_held_freq);
               check("fft_ready_in_out", fft_ready, 0);
            end

            if (freq_valid && freq_ready) begin
               if (exp_q.size() == 0) begin
                  fail("unexpected_transfer");
               end else begin
                  e = exp_q.pop_front();
                  check("freq", freq, e.freq);
                  check("frame_cnt_before", frame_cnt, e.pre_cnt);
                  mon_last_pre  = e.pre_cnt;
                  mon_prev_xfer = 1'b1;
               end
            end
            mon_prev_valid = freq_valid;
         end
      end
   end

   // ------------------------------------------------------------ stimulus
   task automatic do_reset();
      @(posedge clk);
      #1;
      rst       = 1'b0;
      fft_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      exp_q.delete();
      model_cnt = 0;
      @(negedge clk);
      check("rst_fft_ready", fft_ready, 1);
      check("rst_freq_valid", freq_valid, 0);
      check("rst_frame_cnt", frame_cnt, 0);
      check("rst_all_done", all_done, 0);
      check("rst_freq", freq, 0);
   endtask

   // gap_mode: 0 back-to-back, 1 valid toggles 1/0, 2 random idle gaps.
   // Sends bins 0..n-1 of frm; a full frame pushes its expected result.
   task automatic send_frame(input int n, input int gap_mode);
      int t   = 0;
      int gap = 0;
      int w   = 0;
      @(posedge clk);
      #1;
      for (int k = 0; k < n; k++) begin
         gap = (gap_mode == 1) ? ((k > 0) ? 1 : 0) :
               (gap_mode == 2) ? int'($urandom_range(0, 2)) : 0;
         fft_valid = 1'b0;
         repeat (gap) begin
            @(posedge clk);
            #1;
         end
         fft_d     = frm[k];
         fft_valid = 1'b1;
         w = 0;
         while (w < MAX_WAIT) begin
            @(negedge clk);
            if (fft_ready) break;
            w++;
         end
         if (w >= MAX_WAIT) begin
            fail("bin_accept_timeout");
            fft_valid = 1'b0;
            return;
         end
         t = cyc;
         @(posedge clk);
         #1;
      end
      fft_valid = 1'b0;
      if (n == 16) begin
         exp_q.push_back('{freq: peak_of(frm), pre_cnt: model_cnt, t15: t});
         model_cnt++;
      end
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() > 0 && n < 4 * MAX_WAIT) begin
         @(posedge clk);
         n++;
      end
      if (exp_q.size() > 0) begin
         fail("drain_timeout");
         exp_q.delete();
      end
      @(negedge clk);
      @(negedge clk);
   endtask

   task automatic clear_frame();
      for (int k = 0; k < 16; k++) frm[k] = '0;
   endtask

   // Low-level background with one dominant bin.
   task automatic peak_frame(input int p);
      for (int k = 0; k < 16; k++) frm[k] = {16'(k), 16'(-k)};
      frm[p] = {16'sd1000, 16'sd7};
   endtask

   task automatic rand_frame();
      int mode = int'($urandom_range(0, 3));
      for (int k = 0; k < 16; k++) begin
         case (mode)
            0: frm[k] = $urandom;
            1: frm[k] = {16'(int'($urandom_range(0, 4)) - 2), 16'(int'($urandom_range(0, 4)) - 2)};
            2: frm[k] = ($urandom_range(0, 7) == 0) ? $urandom : 32'h0;
            default: begin
               case ($urandom_range(0, 3))
                  0: frm[k] = 32'h8000_0000;
                  1: frm[k] = 32'h0000_8000;
                  2: frm[k] = 32'h7FFF_8001;
                  default: frm[k] = 32'h8000_8000;
               endcase
            end
         endcase
      end
   endtask

   initial begin
      // Run A: single peak, tie of extremes, all-zero, backpressure.
      do_reset();

      clear_frame();
      frm[5] = {16'sd100, 16'hFFCE};
      send_frame(16, 0);
      drain();

      clear_frame();
      frm[3] = {16'h8000, 16'h0000};
      frm[9] = {16'h0000, 16'h8000};
      send_frame(16, 0);
      drain();

      clear_frame();
      send_frame(16, 0);
      drain();

      peak_frame(11);
      ready_level = 1'b0;
      send_frame(16, 1);
      begin
         int w = 0;
         while (!freq_valid && w < MAX_WAIT) begin
            @(negedge clk);
            w++;
         end
         if (!freq_valid) fail("bp_valid_timeout");
      end
      repeat (10) @(posedge clk);
      #1;
      ready_level = 1'b1;
      drain();

      // Run B: full run of four frames, then halt.
      do_reset();
      peak_frame(0);  send_frame(16, 0);
      peak_frame(15); send_frame(16, 0);
      peak_frame(7);  send_frame(16, 0);
      peak_frame(7);  send_frame(16, 0);
      drain();
      @(posedge clk);
      #1;
      fft_valid = 1'b1;
      fft_d     = 32'h1234_5678;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("halt_no_accept", fft_ready, 0);
         check("halt_freq_valid", freq_valid, 0);
      end
      fft_valid = 1'b0;
      check("halt_frame_cnt", frame_cnt, TB_FRAMES);
      check("halt_all_done", all_done, 1);

      // Run C: reset in the middle of a frame, then a clean frame.
      do_reset();
      peak_frame(6);
      send_frame(8, 0);
      do_reset();
      peak_frame(2);
      send_frame(16, 0);
      drain();

      // Run D: randomized frames, gaps and consumer stalls.
      ready_rand = 1'b1;
      for (int r = 0; r < 3; r++) begin
         do_reset();
         for (int f = 0; f < TB_FRAMES; f++) begin
            rand_frame();
            send_frame(16, 2);
         end
         drain();
         check("run_all_done", all_done, 1);
      end
      ready_rand = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
      $fatal(1, "watchdog expired");
   end

endmodule
